deal_sequencer: RTL and testbench

DEAL_SEQUENCER -- requirements
Module: deal_sequencer

---
 rtl/deal_sequencer.sv | 116 +++++++++++
 tb/tb_deal_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/deal_sequencer.sv
// Baccarat deal sequencer: Moore FSM stepping card loads, third-card draws and the result lights.
// Natural hands settle 6 edges after reset release; player plus banker draws take 9.
module deal_sequencer (
   input  logic       slow_clock,
   input  logic       reset,
   input  logic [3:0] pscore,
   input  logic [3:0] dscore,
   input  logic [3:0] pcard3,
   output logic       load_pcard1,
   output logic       load_pcard2,
   output logic       load_pcard3,
   output logic       load_dcard1,
   output logic       load_dcard2,
   output logic       load_dcard3,
   output logic       player_win_light,
   output logic       dealer_win_light
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_P1     = 4'd1,
      S_D1     = 4'd2,
      S_P2     = 4'd3,
      S_D2     = 4'd4,
      S_EVAL   = 4'd5,
      S_P3     = 4'd6,
      S_BANK   = 4'd7,
      S_D3     = 4'd8,
      S_RESULT = 4'd9
   } state_t;

   state_t     state_q, state_d;
   // Load enables are registered from the next state so they align with state_q.
   // Bit order: {dcard3, dcard2, dcard1, pcard3, pcard2, pcard1}.
   logic [5:0] load_q, load_d;
   logic       banker_draw;

   always_comb begin
      banker_draw = 1'b0;
      case (dscore)
         4'd0, 4'd1, 4'd2: banker_draw = 1'b1;
         4'd3:             banker_draw = (pcard3 != 4'd8);
         4'd4:             banker_draw = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
         4'd5:             banker_draw = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
         4'd6:             banker_draw = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
         default:          banker_draw = 1'b0;
      endcase
   end

   always_comb begin
      state_d = S_IDLE;
      case (state_q)
         S_IDLE: state_d = S_P1;
         S_P1:   state_d = S_D1;
         S_D1:   state_d = S_P2;
         S_P2:   state_d = S_D2;
         S_D2:   state_d = S_EVAL;
         S_EVAL: begin
            if (pscore >= 4'd8 || dscore >= 4'd8)
               state_d = S_RESULT;
            else if (pscore <= 4'd5)
               state_d = S_P3;
            else if (dscore <= 4'd5)
               state_d = S_D3;
            else
               state_d = S_RESULT;
         end
         S_P3:     state_d = S_BANK;
         S_BANK:   state_d = banker_draw ? S_D3 : S_RESULT;
         S_D3:     state_d = S_RESULT;
         S_RESULT: state_d = S_RESULT;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      load_d = 6'b000000;
      case (state_d)
         S_P1:    load_d = 6'b000001;
         S_P2:    load_d = 6'b000010;
         S_P3:    load_d = 6'b000100;
         S_D1:    load_d = 6'b001000;
         S_D2:    load_d = 6'b010000;
         S_D3:    load_d = 6'b100000;
         default: load_d = 6'b000000;
      endcase
   end

   always_ff @(posedge slow_clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         load_q  <= 6'b000000;
      end else begin
         state_q <= state_d;
         load_q  <= load_d;
      end
   end

   assign load_pcard1 = load_q[0];
   assign load_pcard2 = load_q[1];
   assign load_pcard3 = load_q[2];
   assign load_dcard1 = load_q[3];
   assign load_dcard2 = load_q[4];
   assign load_dcard3 = load_q[5];

   // Lights track the live scores once settled; a tie lights both.
   always_comb begin
      player_win_light = 1'b0;
      dealer_win_light = 1'b0;
      if (state_q == S_RESULT) begin
         player_win_light = (pscore >= dscore);
         dealer_win_light = (dscore >= pscore);
      end
   end

endmodule

// File: tb/tb_deal_sequencer.sv
// Randomized and directed hands for deal_sequencer, checked against a baccarat rules model.
module tb_deal_sequencer;

   logic       slow_clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] pscore = 4'd0;
   logic [3:0] dscore = 4'd0;
   logic [3:0] pcard3 = 4'd0;
   logic       load_pcard1, load_pcard2, load_pcard3;
   logic       load_dcard1, load_dcard2, load_dcard3;
   logic       player_win_light, dealer_win_light;

   int n_checks = 0;
   int n_fail   = 0;

   deal_sequencer dut (
      .slow_clock       (slow_clock),
      .reset            (reset),
      .pscore           (pscore),
      .dscore           (dscore),
      .pcard3           (pcard3),
      .load_pcard1      (load_pcard1),
      .load_pcard2      (load_pcard2),
      .load_pcard3      (load_pcard3),
      .load_dcard1      (load_dcard1),
      .load_dcard2      (load_dcard2),
      .load_dcard3      (load_dcard3),
      .player_win_light (player_win_light),
      .dealer_win_light (dealer_win_light)
   );

   always #5 slow_clock = ~slow_clock;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [5:0] load_vec();
      return {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1};
   endfunction

   function automatic logic [1:0] light_vec();
      return {player_win_light, dealer_win_light};
   endfunction

   // Punto banco third-card rule for the banker once the player has drawn.
   function automatic bit banker_rule(input int d, input int c);
      if (d <= 2) return 1'b1;
      if (d == 3) return c != 8;
      if (d >= 7) return 1'b0;
      return (c >= 2 * (d - 3)) && (c <= 7);
   endfunction

   task automatic start_hand(input int p2, input int d2, input string name);
      pscore = 4'(p2);
      dscore = 4'(d2);
      pcard3 = 4'($urandom_range(0, 15));
      @(negedge slow_clock);
      reset = 1'b1;
      #1;
      check_eq({name, " rst_load"}, int'(load_vec()), 0);
      check_eq({name, " rst_light"}, int'(light_vec()), 0);
      @(posedge slow_clock);
      #1;
      check_eq({name, " rst_held"}, int'(load_vec()), 0);
      @(negedge slow_clock);
      reset = 1'b0;
   endtask

   task automatic run_hand(input int p2, input int d2, input int c, input int pf, input int df,
                           input int extra, input string name);
      bit nat, pd, bd;
      int p3e, d3e, re, cp, cd;
      int cnt[6];
      logic [5:0] ev, lv;
      logic [1:0] el;
      nat = (p2 >= 8) || (d2 >= 8);
      pd  = !nat && (p2 <= 5);
      bd  = nat ? 1'b0 : (pd ? banker_rule(d2, c) : (d2 <= 5));
      p3e = -1;
      d3e = -1;
      re  = 6;
      if (pd) begin
         p3e = 6;
         re  = 8;
      end
      if (bd) begin
         d3e = re;
         re  = re + 1;
      end
      foreach (cnt[i]) cnt[i] = 0;
      start_hand(p2, d2, name);
      cp = p2;
      cd = d2;
      for (int k = 1; k <= re + extra; k++) begin
         @(posedge slow_clock);
         #1;
         // Emulate the card datapath: registers update on the edge after their load pulse.
         if (k == p3e + 1) begin
            cp = pf;
            pscore = 4'(pf);
            pcard3 = 4'(c);
         end
         if (d3e > 0 && k == d3e + 1) begin
            cd = df;
            dscore = 4'(df);
         end
         #1;
         ev = 6'b000000;
         if (k == 1)   ev[0] = 1'b1;
         if (k == 2)   ev[3] = 1'b1;
         if (k == 3)   ev[1] = 1'b1;
         if (k == 4)   ev[4] = 1'b1;
         if (k == p3e) ev[2] = 1'b1;
         if (k == d3e) ev[5] = 1'b1;
         lv = load_vec();
         check_eq($sformatf("%s load e%0d", name, k), int'(lv), int'(ev));
         el = 2'b00;
         if (k >= re) el = {cp >= cd, cd >= cp};
         check_eq($sformatf("%s light e%0d", name, k), int'(light_vec()), int'(el));
         for (int b = 0; b < 6; b++) if (lv[b]) cnt[b]++;
      end
      check_eq({name, " cnt_p1"}, cnt[0], 1);
      check_eq({name, " cnt_p2"}, cnt[1], 1);
      check_eq({name, " cnt_p3"}, cnt[2], pd ? 1 : 0);
      check_eq({name, " cnt_d1"}, cnt[3], 1);
      check_eq({name, " cnt_d2"}, cnt[4], 1);
      check_eq({name, " cnt_d3"}, cnt[5], bd ? 1 : 0);
   endtask

   // Abort a player-draws hand after edge at_edge by asserting reset between edges.
   task automatic mid_reset(input int at_edge, input int exp_load, input string name);
      start_hand(3, 3, name);
      for (int k = 1; k <= at_edge; k++) begin
         @(posedge slow_clock);
         #1;
         if (k == 7) pcard3 = 4'd2;
      end
      #1;
      check_eq({name, " pre"}, int'(load_vec()), exp_load);
      #2;
      reset = 1'b1;
      #1;
      check_eq({name, " async_load"}, int'(load_vec()), 0);
      check_eq({name, " async_light"}, int'(light_vec()), 0);
      @(posedge slow_clock);
      #1;
      check_eq({name, " held"}, int'(load_vec()), 0);
      @(negedge slow_clock);
      reset = 1'b0;
      @(posedge slow_clock);
      #1;
      check_eq({name, " restart"}, int'(load_vec()), 1);
      @(posedge slow_clock);
      #1;
      check_eq({name, " restart2"}, int'(load_vec()), 8);
   endtask

   initial begin
      run_hand(8, 3, 5, 0, 0, 2, "natural");
      run_hand(6, 4, 9, 0, 7, 2, "bank_only");
      run_hand(7, 7, 1, 0, 0, 20, "tie");
      run_hand(2, 6, 7, 5, 3, 1, "b6c7");
      run_hand(2, 3, 8, 5, 3, 1, "b3c8");
      run_hand(14, 3, 4, 0, 0, 1, "oob_p");
      run_hand(6, 11, 4, 0, 0, 1, "oob_d");
      run_hand(0, 0, 13, 15, 12, 1, "oob_final");
      mid_reset(6, 4, "rst_p3");
      mid_reset(7, 0, "rst_bank");
      for (int d = 0; d <= 7; d++)
         for (int c = 1; c <= 13; c++)
            run_hand(3, d, c, $urandom_range(0, 9), $urandom_range(0, 9), 0,
                     $sformatf("sweep d%0d c%0d", d, c));
      for (int i = 0; i < 250; i++)
         run_hand($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(1, 13),
                  $urandom_range(0, 9), $urandom_range(0, 9), 1, $sformatf("rnd%0d", i));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
